// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers hex digits from a multiplexed active-low
// 7-segment display bus.
//   iCLK      system clock, rising edge
//   iRST_n    asynchronous active-low reset
//   iSEG7     segment lines, active-low, bit0=a .. bit6=g
//   iDIG      digit select, active-high, expected one-hot
//   iCLR      synchronous clear of oVALID and oERR
//   oHEX      recovered nibbles, digit i at [4i+3:4i]
//   oVALID    per-digit: last accepted pattern was a legal glyph
//   oUPD      one-cycle pulse on each acceptance
//   oUPD_IDX  digit index of the last acceptance
//   oERR      sticky: an illegal non-blank pattern was accepted
module seg7_scan_reader #(
    parameter  int unsigned NUM_DIG    = 4,
    parameter  int unsigned STABLE_CYC = 3,
    localparam int unsigned IDX_W      = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    input  logic [6:0]             iSEG7,
    input  logic [NUM_DIG-1:0]     iDIG,
    input  logic                   iCLR,
    output logic [4*NUM_DIG-1:0]   oHEX,
    output logic [NUM_DIG-1:0]     oVALID,
    output logic                   oUPD,
    output logic [IDX_W-1:0]       oUPD_IDX,
    output logic                   oERR
);

    localparam int unsigned CNT_W = 4;
    localparam logic [6:0]  BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DIG-1:0]     sdig_q, pdig_q;
    logic [6:0]             sseg_q, pseg_q;
    logic [4*NUM_DIG-1:0]   hex_q, hex_d;
    logic [NUM_DIG-1:0]     valid_q, valid_d;
    logic                   upd_q, upd_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_q, err_d;

    logic                   onehot_c;
    logic                   same_c;
    logic [IDX_W-1:0]       sel_idx_c;
    logic [3:0]             nib_c;
    logic                   legal_c;
    logic                   blank_c;
    logic [CNT_W-1:0]       cnt_inc_c;
    logic                   accept_c;

    // Glyph decode of the registered segment sample
    always_comb begin
        nib_c   = 4'h0;
        legal_c = 1'b1;
        case (sseg_q)
            7'b1000000: nib_c = 4'h0;
            7'b1111001: nib_c = 4'h1;
            7'b0100100: nib_c = 4'h2;
            7'b0110000: nib_c = 4'h3;
            7'b0011001: nib_c = 4'h4;
            7'b0010010: nib_c = 4'h5;
            7'b0000010: nib_c = 4'h6;
            7'b1111000: nib_c = 4'h7;
            7'b0000000: nib_c = 4'h8;
            7'b0011000: nib_c = 4'h9;
            7'b0001000: nib_c = 4'hA;
            7'b0000011: nib_c = 4'hB;
            7'b1000110: nib_c = 4'hC;
            7'b0100001: nib_c = 4'hD;
            7'b0000110: nib_c = 4'hE;
            7'b0001110: nib_c = 4'hF;
            default:    legal_c = 1'b0;
        endcase
        blank_c = (sseg_q == BLANK);
    end

    // Select index and sample comparison
    always_comb begin
        sel_idx_c = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (sdig_q[i]) sel_idx_c = IDX_W'(i);
        end
        onehot_c  = $onehot(sdig_q);
        same_c    = (sdig_q == pdig_q) && (sseg_q == pseg_q);
        cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        hex_d    = hex_q;
        valid_d  = iCLR ? '0 : valid_q;
        err_d    = iCLR ? 1'b0 : err_q;
        upd_d    = 1'b0;
        idx_d    = idx_q;

        if (!onehot_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                    cnt_d   = CNT_W'(1);
                end
                ST_TRACK: begin
                    if (same_c) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == CNT_W'(STABLE_CYC)) begin
                            accept_c = 1'b1;
                            state_d  = ST_HOLD;
                        end
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!same_c) begin
                        state_d = ST_TRACK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Acceptance result overrides a same-cycle clear for its digit
        if (accept_c) begin
            upd_d = 1'b1;
            idx_d = sel_idx_c;
            if (!legal_c && !blank_c) err_d = 1'b1;
            for (int i = 0; i < NUM_DIG; i++) begin
                if (sdig_q[i]) begin
                    if (legal_c) begin
                        hex_d[4*i +: 4] = nib_c;
                        valid_d[i]      = 1'b1;
                    end else begin
                        valid_d[i]      = 1'b0;
                    end
                end
            end
        end
    end

    // Input sample, previous sample, FSM and output registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sdig_q  <= '0;
            sseg_q  <= '0;
            pdig_q  <= '0;
            pseg_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hex_q   <= '0;
            valid_q <= '0;
            upd_q   <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            sdig_q  <= iDIG;
            sseg_q  <= iSEG7;
            pdig_q  <= sdig_q;
            pseg_q  <= sseg_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign oHEX     = hex_q;
    assign oVALID   = valid_q;
    assign oUPD     = upd_q;
    assign oUPD_IDX = idx_q;
    assign oERR     = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Testbench for seg7_scan_reader: directed sequences, a glyph vector table
// and randomized scanning, all checked against a run-length reference model.
module tb_seg7_scan_reader;

    localparam int unsigned NUM_DIG    = 4;
    localparam int unsigned STABLE_CYC = 3;
    localparam int unsigned IDX_W      = 2;

    logic                 iCLK = 1'b0;
    logic                 iRST_n;
    logic [6:0]           iSEG7;
    logic [NUM_DIG-1:0]   iDIG;
    logic                 iCLR;
    logic [4*NUM_DIG-1:0] oHEX;
    logic [NUM_DIG-1:0]   oVALID;
    logic                 oUPD;
    logic [IDX_W-1:0]     oUPD_IDX;
    logic                 oERR;

    seg7_scan_reader #(.NUM_DIG(NUM_DIG), .STABLE_CYC(STABLE_CYC)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iSEG7(iSEG7), .iDIG(iDIG), .iCLR(iCLR),
        .oHEX(oHEX), .oVALID(oVALID), .oUPD(oUPD), .oUPD_IDX(oUPD_IDX), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_err    = 0;
    int upd_cnt  = 0;

    // Reference model: a pattern is accepted when the run of identical
    // one-hot samples reaches exactly STABLE_CYC.
    logic [NUM_DIG-1:0] m_dig, m_ldig;
    logic [6:0]         m_seg, m_lseg;
    int                 m_run;
    logic [3:0]         e_hex [NUM_DIG];
    logic [NUM_DIG-1:0] e_valid;
    logic               e_upd;
    logic [IDX_W-1:0]   e_idx;
    logic               e_err;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_dig = '0; m_ldig = '0; m_seg = '0; m_lseg = '0; m_run = 0;
        for (int k = 0; k < NUM_DIG; k++) e_hex[k] = 4'h0;
        e_valid = '0; e_upd = 1'b0; e_idx = '0; e_err = 1'b0;
    endfunction

    function automatic void model_step();
        int pos;
        int nib;
        bit onehot;
        if (!iRST_n) begin
            model_reset();
            return;
        end
        onehot = ($countones(m_dig) == 1);
        if (onehot) m_run = (m_run > 0 && m_dig == m_ldig && m_seg == m_lseg) ? m_run + 1 : 1;
        else        m_run = 0;
        e_upd = 1'b0;
        if (iCLR) begin
            e_valid = '0;
            e_err   = 1'b0;
        end
        if (onehot && m_run == STABLE_CYC) begin
            pos = 0;
            for (int k = 0; k < NUM_DIG; k++) if (m_dig[k]) pos = k;
            nib = -1;
            for (int k = 0; k < 16; k++) if (glyph[k] == m_seg) nib = k;
            e_upd = 1'b1;
            e_idx = IDX_W'(pos);
            if (nib >= 0) begin
                e_hex[pos]   = 4'(nib);
                e_valid[pos] = 1'b1;
            end else begin
                e_valid[pos] = 1'b0;
                if (m_seg != 7'b1111111) e_err = 1'b1;
            end
        end
        m_ldig = m_dig; m_lseg = m_seg;
        m_dig  = iDIG;  m_seg  = iSEG7;
    endfunction

    task automatic tick();
        logic [4*NUM_DIG-1:0] eh;
        @(posedge iCLK);
        model_step();
        #1;
        for (int k = 0; k < NUM_DIG; k++) eh[4*k +: 4] = e_hex[k];
        check("model", {oHEX, oVALID, oUPD, oUPD_IDX, oERR}, {eh, e_valid, e_upd, e_idx, e_err});
    endtask

    task automatic apply(input logic [NUM_DIG-1:0] d, input logic [6:0] s, input int n);
        iDIG = d; iSEG7 = s;
        repeat (n) begin
            tick();
            if (oUPD) upd_cnt++;
        end
    endtask

    task automatic pulse_reset();
        iRST_n = 1'b0;
        model_reset();
        #1;
        check("rst_clear", {oHEX, oVALID, oUPD, oUPD_IDX, oERR}, '0);
        repeat (2) tick();
        #3 iRST_n = 1'b1;
    endtask

    typedef struct {
        int         dig;
        logic [6:0] seg;
        logic [3:0] nib;
        logic       vld;
        logic       err;
    } vec_t;

    vec_t       vecs [19];
    logic [3:0] last_nib [NUM_DIG];
    logic [3:0] exp_nib;

    initial begin
        iRST_n = 1'b0; iDIG = '0; iSEG7 = 7'b1111111; iCLR = 1'b0;
        model_reset();

        // Reset then idle
        #12;
        check("reset_out", {oHEX, oVALID, oUPD, oUPD_IDX, oERR}, '0);
        iRST_n = 1'b1;
        upd_cnt = 0;
        apply('0, 7'b1111111, 20);
        check("idle_no_upd", 64'(upd_cnt), 0);
        check("idle_out", {oHEX, oVALID, oUPD, oUPD_IDX, oERR}, '0);

        // Basic capture: accepted on the third edge after the sample edge
        iDIG = 4'b0001; iSEG7 = 7'b0000010;
        tick(); tick(); tick();
        check("cap_early_upd", oUPD, 0);
        tick();
        check("cap_upd", oUPD, 1);
        check("cap_hex", oHEX[3:0], 4'h6);
        check("cap_valid", oVALID, 4'b0001);
        check("cap_idx", oUPD_IDX, 0);
        upd_cnt = 0;
        apply(4'b0001, 7'b0000010, 10);
        check("cap_hold_no_upd", 64'(upd_cnt), 0);

        // Two scans of 1, A, 0, F with a 5-cycle dwell
        upd_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 4; d++) begin
                logic [6:0] p;
                case (d)
                    0: p = 7'b1111001;
                    1: p = 7'b0001000;
                    2: p = 7'b1000000;
                    default: p = 7'b0001110;
                endcase
                iDIG = NUM_DIG'(1 << d); iSEG7 = p;
                repeat (5) begin
                    tick();
                    if (oUPD) begin
                        upd_cnt++;
                        check("scan_idx", oUPD_IDX, d);
                    end
                end
            end
        end
        check("scan_upd_count", 64'(upd_cnt), 8);
        check("scan_hex", oHEX, 16'hF0A1);
        check("scan_valid", oVALID, 4'b1111);

        // Glitch rejection on digit 2
        apply('0, 7'b1111111, 2);
        upd_cnt = 0;
        apply(4'b0100, 7'b0011001, 1);
        apply(4'b0100, 7'b0000000, 1);
        apply(4'b0100, 7'b0011001, 2);
        apply('0, 7'b1111111, 3);
        check("glitch_no_upd", 64'(upd_cnt), 0);
        check("glitch_hex_kept", oHEX[11:8], 4'h0);
        upd_cnt = 0;
        apply(4'b0100, 7'b0011001, 1);
        apply(4'b0100, 7'b0000000, 1);
        apply(4'b0100, 7'b0011001, 3);
        apply('0, 7'b1111111, 3);
        check("glitch_one_upd", 64'(upd_cnt), 1);
        check("glitch_hex4", oHEX[11:8], 4'h4);
        check("glitch_valid", oVALID[2], 1);

        // Illegal, then blank, then clear
        apply(4'b0010, 7'b1010101, 5);
        check("ill_err", oERR, 1);
        check("ill_valid", oVALID[1], 0);
        apply(4'b0010, 7'b1111111, 5);
        check("blank_valid", oVALID[1], 0);
        check("blank_err_sticky", oERR, 1);
        check("blank_hex_kept", oHEX[7:4], 4'hA);
        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
        check("clr_err", oERR, 0);
        check("clr_valid", oVALID, 4'b0000);

        // Multi-hot select never captures
        upd_cnt = 0;
        apply(4'b0011, 7'b0000000, 10);
        check("multihot_no_upd", 64'(upd_cnt), 0);

        // Reset in mid-track discards the partial count
        iDIG = 4'b0100; iSEG7 = 7'b0110000;
        tick(); tick(); tick();
        pulse_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) check("rst_wait_no_upd", oUPD, 0);
            else       check("rst_recapture", oUPD, 1);
        end
        check("rst_recap_hex", oHEX[11:8], 4'h3);

        // Glyph table vectors
        vecs[0]  = '{0, 7'b1000000, 4'h0, 1'b1, 1'b0};
        vecs[1]  = '{1, 7'b1111001, 4'h1, 1'b1, 1'b0};
        vecs[2]  = '{2, 7'b0100100, 4'h2, 1'b1, 1'b0};
        vecs[3]  = '{3, 7'b0110000, 4'h3, 1'b1, 1'b0};
        vecs[4]  = '{0, 7'b0011001, 4'h4, 1'b1, 1'b0};
        vecs[5]  = '{1, 7'b0010010, 4'h5, 1'b1, 1'b0};
        vecs[6]  = '{2, 7'b0000010, 4'h6, 1'b1, 1'b0};
        vecs[7]  = '{3, 7'b1111000, 4'h7, 1'b1, 1'b0};
        vecs[8]  = '{0, 7'b0000000, 4'h8, 1'b1, 1'b0};
        vecs[9]  = '{1, 7'b0011000, 4'h9, 1'b1, 1'b0};
        vecs[10] = '{2, 7'b0001000, 4'hA, 1'b1, 1'b0};
        vecs[11] = '{3, 7'b0000011, 4'hB, 1'b1, 1'b0};
        vecs[12] = '{0, 7'b1000110, 4'hC, 1'b1, 1'b0};
        vecs[13] = '{1, 7'b0100001, 4'hD, 1'b1, 1'b0};
        vecs[14] = '{2, 7'b0000110, 4'hE, 1'b1, 1'b0};
        vecs[15] = '{3, 7'b0001110, 4'hF, 1'b1, 1'b0};
        vecs[16] = '{1, 7'b1111111, 4'h0, 1'b0, 1'b0};
        vecs[17] = '{2, 7'b0000001, 4'h0, 1'b0, 1'b1};
        vecs[18] = '{3, 7'b1111110, 4'h0, 1'b0, 1'b1};
        pulse_reset();
        for (int k = 0; k < NUM_DIG; k++) last_nib[k] = 4'h0;
        for (int i = 0; i < 19; i++) begin
            iCLR = 1'b1; iDIG = '0;
            tick();
            iCLR = 1'b0;
            tick();
            apply(NUM_DIG'(1 << vecs[i].dig), vecs[i].seg, STABLE_CYC + 2);
            exp_nib = vecs[i].vld ? vecs[i].nib : last_nib[vecs[i].dig];
            check($sformatf("tbl%0d_hex", i), oHEX[4*vecs[i].dig +: 4], exp_nib);
            check($sformatf("tbl%0d_valid", i), oVALID[vecs[i].dig], vecs[i].vld);
            check($sformatf("tbl%0d_err", i), oERR, vecs[i].err);
            if (vecs[i].vld) last_nib[vecs[i].dig] = vecs[i].nib;
        end

        // Randomized scanning against the model
        for (int it = 0; it < 600; it++) begin
            int r;
            int dwell;
            logic [NUM_DIG-1:0] d;
            logic [6:0] s;
            r = $urandom_range(0, 9);
            if (r == 0)      d = '0;
            else if (r == 1) d = NUM_DIG'($urandom);
            else             d = NUM_DIG'(1 << $urandom_range(0, NUM_DIG - 1));
            r = $urandom_range(0, 9);
            if (r < 7)       s = glyph[$urandom_range(0, 15)];
            else if (r == 7) s = 7'b1111111;
            else             s = 7'($urandom);
            dwell = $urandom_range(1, 6);
            iDIG = d; iSEG7 = s;
            for (int c = 0; c < dwell; c++) begin
                iCLR = ($urandom_range(0, 15) == 0);
                tick();
            end
            iCLR = 1'b0;
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
